// File: rtl/gpr_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, GPR write port and scoreboard hazard taps.
// master = requesters/decode side, slave = arbiter side.
interface gpr_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_en;
  logic [4:0]           wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 claim_en;
  logic [4:0]           claim_addr;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [31:0]          pending;

  modport master (
    output req_valid, req_addr, req_data, claim_en, claim_addr, rs1_addr, rs2_addr,
    input  req_ready, wb_en, wb_addr, wb_data, rs1_busy, rs2_busy, pending
  );

  modport slave (
    input  req_valid, req_addr, req_data, claim_en, claim_addr, rs1_addr, rs2_addr,
    output req_ready, wb_en, wb_addr, wb_data, rs1_busy, rs2_busy, pending
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: round-robin grant, registered write port, pending-write scoreboard.
// Define WB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

// Per-requester slice: passes its addr/data only when granted so the top can OR-reduce.
module gpr_wb_lane #(
  parameter int XLEN = 64
) (
  input  logic            gnt_i,
  input  logic [4:0]      addr_i,
  input  logic [XLEN-1:0] data_i,
  output logic [4:0]      addr_o,
  output logic [XLEN-1:0] data_o
);
  assign addr_o = gnt_i ? addr_i : 5'd0;
  assign data_o = gnt_i ? data_i : '0;
endmodule

module gpr_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            rst_n,
  gpr_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic            en;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_t;

  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0][4:0]      lane_addr;
  logic [NREQ-1:0][XLEN-1:0] lane_data;
  logic [4:0]                sel_addr;
  logic [XLEN-1:0]           sel_data;
  wb_t                       wb_q, wb_d;
  logic [31:0]               pending_q, pending_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    gpr_wb_lane #(.XLEN(XLEN)) u_lane (
      .gnt_i  (grant[i]),
      .addr_i (bus.req_addr[5*i +: 5]),
      .data_i (bus.req_data[XLEN*i +: XLEN]),
      .addr_o (lane_addr[i]),
      .data_o (lane_data[i])
    );
  end

  always_comb begin
    sel_addr = 5'd0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr |= lane_addr[i];
      sel_data |= lane_data[i];
    end
  end

`ifdef WB_FIXED_PRIO_EN
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] idx_b;
  logic          found;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx_b    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_b = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx_b]) begin
        found        = 1'b1;
        grant[idx_b] = 1'b1;
        rr_ptr_d     = idx_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= PW'(NREQ - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    wb_d    = wb_q;
    wb_d.en = 1'b0;
    if (|grant) begin
      wb_d.en   = (sel_addr != 5'd0);
      wb_d.addr = sel_addr;
      wb_d.data = sel_data;
    end
  end

  // Retire clears first so a same-cycle claim of the same register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_q.en) pending_d[wb_q.addr] = 1'b0;
    if (bus.claim_en && bus.claim_addr != 5'd0) pending_d[bus.claim_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      pending_q <= '0;
    end else begin
      wb_q      <= wb_d;
      pending_q <= pending_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.wb_en     = wb_q.en;
  assign bus.wb_addr   = wb_q.addr;
  assign bus.wb_data   = wb_q.data;
  assign bus.pending   = pending_q;
  assign bus.rs1_busy  = pending_q[bus.rs1_addr];
  assign bus.rs2_busy  = pending_q[bus.rs2_addr];
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: expected writebacks queued at each posedge, popped and checked next cycle.
module tb_gpr_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] DA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [XLEN-1:0] DB = 64'hBBBB_0000_BBBB_0002;
  localparam logic [XLEN-1:0] DC = 64'hCCCC_0000_CCCC_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus();
  gpr_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic            en;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t             sb[$];
  wb_t             e;
  int              vecs = 0;
  int              errs = 0;
  int              m_ptr;
  logic            m_en;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [31:0]     m_pend;
  logic [NREQ-1:0] exp_g;

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g = '0;
`ifdef WB_FIXED_PRIO_EN
    for (int i = NREQ-1; i >= 0; i--) if (v[i]) g = NREQ'(1) << i;
`else
    for (int k = NREQ; k >= 1; k--) if (v[(ptr + k) % NREQ]) g = NREQ'(1) << ((ptr + k) % NREQ);
`endif
    return g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
    bus.req_valid[i]             = v;
    bus.req_addr[5*i +: 5]       = a;
    bus.req_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic model_reset();
    m_ptr = NREQ - 1; m_en = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;
    sb.delete();
  endtask

  // Advance one cycle: update the reference model at posedge, queue the expected write, return at negedge.
  task automatic clk_edge();
    logic [NREQ-1:0] g;
    logic [31:0]     np;
    wb_t             w;
    @(posedge clk);
    g  = model_grant(bus.req_valid, m_ptr);
    np = m_pend;
    if (m_en) np[m_addr] = 1'b0;
    if (bus.claim_en && bus.claim_addr != 5'd0) np[bus.claim_addr] = 1'b1;
    np[0] = 1'b0;
    m_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        m_addr = bus.req_addr[5*i +: 5];
        m_data = bus.req_data[XLEN*i +: XLEN];
        m_en   = (m_addr != 5'd0);
        m_ptr  = i;
      end
    end
    m_pend = np;
    w.en = m_en; w.addr = m_addr; w.data = m_data;
    sb.push_back(w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.claim_en = 1'b0; bus.claim_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    set_req(0, 1'b1, 5'd5, DA);
    set_req(1, 1'b1, 5'd6, DB);
    set_req(2, 1'b1, 5'd7, DC);
    #2;
    vecs++; if (bus.wb_en !== 1'b0)    begin errs++; $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
    vecs++; if (bus.wb_addr !== 5'd0)  begin errs++; $display("FAIL reset_wb_addr got=%0d exp=0", bus.wb_addr); end
    vecs++; if (bus.wb_data !== '0)    begin errs++; $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data); end
    vecs++; if (bus.pending !== 32'd0) begin errs++; $display("FAIL reset_pending got=%h exp=0", bus.pending); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] hard;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_g = model_grant(bus.req_valid, m_ptr);
`ifdef WB_FIXED_PRIO_EN
      hard = 3'b001;
`else
      hard = NREQ'(1) << (c % NREQ);
`endif
      vecs++; if (bus.req_ready !== exp_g) begin errs++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_g); end
      vecs++; if (bus.req_ready !== hard)  begin errs++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, bus.req_ready, hard); end
      clk_edge();
      e = sb.pop_front();
      vecs++;
      if (bus.wb_en !== e.en || bus.wb_addr !== e.addr || bus.wb_data !== e.data) begin
        errs++; $display("FAIL rr_wb c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.wb_en, bus.wb_addr, bus.wb_data, e.en, e.addr, e.data);
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b1, 5'd3, 64'hDEADBEEF);
    set_req(2, 1'b0, 5'd0, '0);
    #1;
    vecs++; if (bus.req_ready !== 3'b010) begin errs++; $display("FAIL single_ready got=%b exp=010", bus.req_ready); end
    clk_edge();
    e = sb.pop_front();
    vecs++;
    if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd3 || bus.wb_data !== 64'hDEADBEEF || e.addr !== 5'd3) begin
      errs++; $display("FAIL single_wb got=%b/%0d/%h exp=1/3/deadbeef", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    set_req(1, 1'b0, 5'd3, 64'hDEADBEEF);
    #1;
    vecs++; if (bus.req_ready !== 3'b000) begin errs++; $display("FAIL idle_ready got=%b exp=000", bus.req_ready); end
    clk_edge();
    e = sb.pop_front();
    vecs++; if (bus.wb_en !== 1'b0 || bus.wb_addr !== e.addr) begin errs++; $display("FAIL idle_wb got=%b/%0d exp=0/%0d", bus.wb_en, bus.wb_addr, e.addr); end
  endtask

  task automatic test_x0();
    set_req(0, 1'b1, 5'd0, 64'h1);
    set_req(1, 1'b1, 5'd9, 64'h2);
    #1;
    vecs++; if (bus.req_ready !== 3'b001) begin errs++; $display("FAIL x0_ready got=%b exp=001", bus.req_ready); end
    clk_edge();
    e = sb.pop_front();
    vecs++; if (bus.wb_en !== 1'b0 || e.en !== 1'b0) begin errs++; $display("FAIL x0_wb_en got=%b exp=0", bus.wb_en); end
    vecs++; if (bus.pending[0] !== 1'b0) begin errs++; $display("FAIL x0_pending got=%b exp=0", bus.pending[0]); end
`ifdef WB_FIXED_PRIO_EN
    set_req(0, 1'b0, 5'd0, 64'h1);
`endif
    #1;
    vecs++; if (bus.req_ready !== 3'b010) begin errs++; $display("FAIL x0_next_ready got=%b exp=010", bus.req_ready); end
    clk_edge();
    e = sb.pop_front();
    vecs++;
    if (bus.wb_en !== e.en || bus.wb_addr !== 5'd9 || bus.wb_data !== e.data) begin
      errs++; $display("FAIL x0_next_wb got=%b/%0d/%h exp=%b/9/%h", bus.wb_en, bus.wb_addr, bus.wb_data, e.en, e.data);
    end
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd0, '0);
    clk_edge();
    e = sb.pop_front();
  endtask

  task automatic test_claim();
    bus.claim_en = 1'b1; bus.claim_addr = 5'd10; bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11;
    clk_edge();
    bus.claim_en = 1'b0;
    e = sb.pop_front();
    vecs++; if (bus.rs1_busy !== 1'b1) begin errs++; $display("FAIL claim_rs1_busy got=%b exp=1", bus.rs1_busy); end
    vecs++; if (bus.rs2_busy !== 1'b0) begin errs++; $display("FAIL claim_rs2_busy got=%b exp=0", bus.rs2_busy); end
    vecs++; if (bus.pending !== m_pend) begin errs++; $display("FAIL claim_pending got=%h exp=%h", bus.pending, m_pend); end
    set_req(2, 1'b1, 5'd10, 64'h1234);
    #1;
    vecs++; if (bus.req_ready !== 3'b100) begin errs++; $display("FAIL claim_ready got=%b exp=100", bus.req_ready); end
    clk_edge();
    set_req(2, 1'b0, 5'd0, '0);
    e = sb.pop_front();
    vecs++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== e.addr) begin errs++; $display("FAIL claim_wb got=%b/%0d exp=1/%0d", bus.wb_en, bus.wb_addr, e.addr); end
    vecs++; if (bus.rs1_busy !== 1'b1) begin errs++; $display("FAIL wbcycle_rs1_busy got=%b exp=1", bus.rs1_busy); end
    clk_edge();
    e = sb.pop_front();
    vecs++; if (bus.rs1_busy !== 1'b0) begin errs++; $display("FAIL retire_rs1_busy got=%b exp=0", bus.rs1_busy); end
    vecs++; if (bus.pending !== 32'd0) begin errs++; $display("FAIL retire_pending got=%h exp=0", bus.pending); end
  endtask

  task automatic test_set_wins();
    bus.claim_en = 1'b1; bus.claim_addr = 5'd12;
    clk_edge();
    bus.claim_en = 1'b0;
    e = sb.pop_front();
    set_req(0, 1'b1, 5'd12, 64'h5);
    clk_edge();
    set_req(0, 1'b0, 5'd0, '0);
    e = sb.pop_front();
    vecs++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd12) begin errs++; $display("FAIL setwins_wb got=%b/%0d exp=1/12", bus.wb_en, bus.wb_addr); end
    bus.claim_en = 1'b1; bus.claim_addr = 5'd12;
    clk_edge();
    e = sb.pop_front();
    vecs++; if (bus.pending[12] !== 1'b1) begin errs++; $display("FAIL setwins_pending12 got=%b exp=1", bus.pending[12]); end
    vecs++; if (bus.pending !== m_pend) begin errs++; $display("FAIL setwins_pending got=%h exp=%h", bus.pending, m_pend); end
    bus.claim_addr = 5'd0;
    clk_edge();
    bus.claim_en = 1'b0;
    e = sb.pop_front();
    vecs++; if (bus.pending !== 32'h0000_1000) begin errs++; $display("FAIL claim_x0_pending got=%h exp=00001000", bus.pending); end
    set_req(1, 1'b1, 5'd12, 64'h6);
    clk_edge();
    set_req(1, 1'b0, 5'd0, '0);
    e = sb.pop_front();
    clk_edge();
    e = sb.pop_front();
    vecs++; if (bus.pending !== 32'd0) begin errs++; $display("FAIL setwins_clear got=%h exp=0", bus.pending); end
  endtask

  task automatic test_reset_mid();
    bus.claim_en = 1'b1; bus.claim_addr = 5'd10;
    set_req(1, 1'b1, 5'd10, 64'h77);
    clk_edge();
    bus.claim_en = 1'b0;
    e = sb.pop_front();
    vecs++; if (bus.wb_en !== 1'b1 || bus.pending !== 32'h0000_0400) begin errs++; $display("FAIL pre_reset got=%b/%h exp=1/00000400", bus.wb_en, bus.pending); end
    set_req(0, 1'b1, 5'd5, DA);
    set_req(2, 1'b1, 5'd7, DC);
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.wb_en !== 1'b0 || bus.pending !== 32'd0 || bus.wb_addr !== 5'd0) begin
      errs++; $display("FAIL async_reset got=%b/%h/%0d exp=0/0/0", bus.wb_en, bus.pending, bus.wb_addr);
    end
    model_reset();
    set_req(1, 1'b1, 5'd6, DB);
    rst_n = 1'b1;
    #1;
    vecs++; if (bus.req_ready !== 3'b001) begin errs++; $display("FAIL post_reset_ready got=%b exp=001", bus.req_ready); end
    clk_edge();
    e = sb.pop_front();
    vecs++;
    if (bus.wb_en !== e.en || bus.wb_addr !== 5'd5 || bus.wb_data !== DA) begin
      errs++; $display("FAIL post_reset_wb got=%b/%0d/%h exp=1/5/%h", bus.wb_en, bus.wb_addr, bus.wb_data, DA);
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_x0();
    test_claim();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR file write port among NREQ writeback requesters (ALU, load unit, CSR unit, ...) using round-robin arbitration.
- Registers the winning write into an output stage that drives the register file's write enable, address and data. The register file commits that write on the falling edge of the same cycle.
- Keeps a 32-bit pending-write scoreboard, set by decode at issue and cleared at writeback retire, and reports read-after-write hazards for two source operands.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 64, data width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester write request
req_addr  in  NREQ*5  per-requester destination register; requester i uses bits [5i+4:5i]
req_data  in  NREQ*XLEN  per-requester write data; requester i uses slice i
req_ready  out  NREQ  one-hot grant; request is accepted on the posedge where valid&ready
wb_en  out  1  to GPR write enable (RRW[0] equivalent)
wb_addr  out  5  to GPR rdaddr
wb_data  out  XLEN  to GPR rd
claim_en  in  1  decode issues an instruction that will write claim_addr
claim_addr  in  5  destination being claimed
rs1_addr  in  5  source operand 1 for hazard check
rs2_addr  in  5  source operand 2 for hazard check
rs1_busy  out  1  rs1_addr has a pending write
rs2_busy  out  1  rs2_addr has a pending write
pending  out  32  scoreboard bitmap; bit 0 is always 0

Behaviour:
- Reset (async, rst_n=0): wb_en=0, wb_addr=0, wb_data=0, pending=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- Arbitration is combinational.
  - Search req_valid starting at index (rr_ptr+1) mod NREQ, wrapping around.
  - The first valid requester gets req_ready=1. All other ready bits are 0, and all are 0 if no request is valid.
  - The output stage never back-pressures: exactly one grant per cycle whenever any request is valid.
- rr_ptr updates to the granted index on an accepting posedge and holds otherwise.
- Requesters hold valid, addr and data stable until ready. Dropping valid before grant is permitted; the request is simply withdrawn.
- Output stage, registered. On the posedge accepting requester g:
  - wb_en <= (addr_g != 0), wb_addr <= addr_g, wb_data <= data_g.
  - With no accept, wb_en <= 0 and wb_addr/wb_data hold their values.
  - Latency: accepted at posedge k, wb_en high during cycle k..k+1, GPR writes at the negedge inside that cycle.
- Writes to x0 are accepted (ready asserted, rr_ptr advances) but produce wb_en=0.
- Scoreboard, updated on posedge:
  - Clear bit wb_addr when wb_en=1 (retire at the end of the wb cycle, after the GPR negedge commit).
  - Set bit claim_addr when claim_en=1 and claim_addr != 0.
  - Same address set and cleared in the same cycle: set wins, because the new producer is outstanding.
  - Claiming an already-pending register leaves it pending. No counting: decode must not issue a second writer to a pending register, since busy stalls it.
- rs1_busy = pending[rs1_addr], rs2_busy = pending[rs2_addr], combinational. x0 is never busy.
- Reset mid-operation: in-flight wb_en is dropped, scoreboard cleared, arbitration restarts at requester 0.

Optional Feature:
Macro WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and req_ready = lowest set bit of req_valid.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with all req_valid=1 (NREQ=3), addrs 5/6/7, data A/B/C.
  - Round-robin: grants 0,1,2,0 on consecutive cycles; wb_addr 5,6,7,5 one cycle later, wb_data A,B,C,A.
  - WB_FIXED_PRIO_EN: grant stays at 0 every cycle.
- Single request from requester 1 to x3 with data 0xDEADBEEF: req_ready[1]=1 same cycle; next cycle wb_en=1, wb_addr=3, wb_data=0xDEADBEEF; following idle cycle wb_en=0.
- Request to x0 from requester 0: req_ready[0]=1, wb_en stays 0, pending[0] stays 0; the next grant goes to requester 1 if it is valid.
- claim_en with addr 10, rs1_addr=10: rs1_busy=1 the cycle after claim. A writeback to x10 raises wb_en; rs1_busy falls after that wb cycle's posedge.
- Simultaneous claim of x12 and wb_en retire of x12: pending[12] remains 1. Claim of x0: pending stays 0.
- Assert rst_n=0 mid-stream with wb_en=1 and pending=0x0000_0400: wb_en, pending and wb_addr go to 0 immediately (async). After release, the first grant goes to requester 0.
